// File: rtl/fast_serial_pkg.sv
// rtl/fast_serial_pkg.sv - frame constants, FSM state types and frame builder for fast_serial_link
package fast_serial_pkg;

  localparam int   FRAME_BITS = 10;
  localparam logic START_BIT  = 1'b0;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SHIFT,
    TX_GAP
  } tx_state_t;

  typedef enum logic {
    RX_IDLE,
    RX_SHIFT
  } rx_state_t;

  // Serial order is bit 0 first: start, D0..D7, source bit.
  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] data, input logic src);
    return {src, data, START_BIT};
  endfunction

endpackage

// File: rtl/fast_serial_fifo.sv
// rtl/fast_serial_fifo.sv - show-ahead synchronous FIFO with occupancy count
module fast_serial_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  // Held not-ready during reset so nothing is accepted into a FIFO being cleared.
  assign wr_ready = (count != (AW+1)'(DEPTH)) && !reset;
  assign rd_valid = (count != '0);
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_valid && rd_ready;
  assign rd_data  = mem[rd_ptr];
  assign level    = count;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fast_serial_link.sv
// rtl/fast_serial_link.sv - FT2232 fast-opto-serial transceiver: FSCLK divider, TX/RX FSMs, byte FIFOs
// Optional internal loopback selected by FAST_SERIAL_LOOPBACK_EN.
module fast_serial_link
  import fast_serial_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int TX_DEPTH   = 16,
  parameter int RX_DEPTH   = 16,
  parameter bit TX_CHANNEL = 1'b0
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
`ifdef FAST_SERIAL_LOOPBACK_EN
  input  logic                      i_loopback,
`endif
  input  logic [7:0]                i_tx_data,
  input  logic                      i_tx_valid,
  output logic                      o_tx_ready,
  output logic [7:0]                o_rx_data,
  output logic                      o_rx_channel,
  output logic                      o_rx_valid,
  input  logic                      i_rx_ready,
  output logic                      o_rx_overflow,
  output logic [$clog2(TX_DEPTH):0] o_tx_level,
  output logic [$clog2(RX_DEPTH):0] o_rx_level,
  output logic                      o_fsclk,
  output logic                      o_fsdi,
  input  logic                      i_fsdo,
  input  logic                      i_fscts
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic             fsclk_q;
  logic             div_term;
  logic             rise_stb;
  logic             fall_stb;

  logic             fsdi_q;
  logic             fsdo_r;
  logic             fscts_r;
  logic             rx_pin;
  logic             cts_pin;

  tx_state_t             tx_state, tx_next;
  logic [FRAME_BITS-1:0] tx_sh;
  logic [3:0]            tx_cnt;
  logic                  tx_pop;
  logic                  tx_shift;
  logic                  tx_end;
  logic [7:0]            tx_head;
  logic                  tx_avail;

  rx_state_t             rx_state, rx_next;
  logic [FRAME_BITS-2:0] rx_sh;
  logic [3:0]            rx_cnt;
  logic                  rx_sample;
  logic                  rx_done;
  logic                  rx_wr_pend;
  logic                  rx_wr_ready;
  logic [8:0]            rx_head;

  assign div_term = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign rise_stb = div_term && !fsclk_q;
  assign fall_stb = div_term && fsclk_q;
  assign o_fsclk  = fsclk_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      div_cnt <= '0;
      fsclk_q <= 1'b0;
    end else if (div_term) begin
      div_cnt <= '0;
      fsclk_q <= ~fsclk_q;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

`ifdef FAST_SERIAL_LOOPBACK_EN
  // Loopback feeds the serializer straight into the receiver and keeps the pin idle.
  assign rx_pin  = i_loopback ? fsdi_q : i_fsdo;
  assign cts_pin = i_loopback ? 1'b1 : i_fscts;
  assign o_fsdi  = i_loopback ? IDLE_LEVEL : fsdi_q;
`else
  assign rx_pin  = i_fsdo;
  assign cts_pin = i_fscts;
  assign o_fsdi  = fsdi_q;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fsdo_r  <= IDLE_LEVEL;
      fscts_r <= 1'b0;
    end else begin
      fsdo_r  <= rx_pin;
      fscts_r <= cts_pin;
    end
  end

  always_comb begin
    tx_next  = tx_state;
    tx_pop   = 1'b0;
    tx_shift = 1'b0;
    tx_end   = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (rise_stb && tx_avail && fscts_r) begin
          tx_pop  = 1'b1;
          tx_next = TX_SHIFT;
        end
      end
      TX_SHIFT: begin
        if (fall_stb) begin
          if (tx_cnt == 4'(FRAME_BITS)) begin
            tx_end  = 1'b1;
            tx_next = TX_GAP;
          end else begin
            tx_shift = 1'b1;
          end
        end
      end
      TX_GAP: begin
        if (fall_stb) begin
          tx_next = TX_IDLE;
        end
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tx_state <= TX_IDLE;
      tx_sh    <= {FRAME_BITS{IDLE_LEVEL}};
      tx_cnt   <= '0;
      fsdi_q   <= IDLE_LEVEL;
    end else begin
      tx_state <= tx_next;
      if (tx_pop) begin
        tx_sh  <= make_frame(tx_head, TX_CHANNEL);
        tx_cnt <= '0;
      end else if (tx_shift) begin
        fsdi_q <= tx_sh[0];
        tx_sh  <= {IDLE_LEVEL, tx_sh[FRAME_BITS-1:1]};
        tx_cnt <= tx_cnt + 1'b1;
      end
      if (tx_end) begin
        fsdi_q <= IDLE_LEVEL;
      end
    end
  end

  always_comb begin
    rx_next   = rx_state;
    rx_sample = 1'b0;
    rx_done   = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rise_stb && (fsdo_r == START_BIT)) begin
          rx_next = RX_SHIFT;
        end
      end
      RX_SHIFT: begin
        if (rise_stb) begin
          rx_sample = 1'b1;
          if (rx_cnt == 4'(FRAME_BITS - 2)) begin
            rx_done = 1'b1;
            rx_next = RX_IDLE;
          end
        end
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  // Bits enter at the top so after nine samples D0 sits at bit 0 and the source bit at bit 8.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_state   <= RX_IDLE;
      rx_sh      <= '0;
      rx_cnt     <= '0;
      rx_wr_pend <= 1'b0;
    end else begin
      rx_state   <= rx_next;
      rx_wr_pend <= rx_done;
      if (rx_sample) begin
        rx_sh  <= {fsdo_r, rx_sh[FRAME_BITS-2:1]};
        rx_cnt <= rx_cnt + 1'b1;
      end else if (rx_state == RX_IDLE) begin
        rx_cnt <= '0;
      end
    end
  end

  assign o_rx_overflow = rx_wr_pend && !rx_wr_ready && !i_reset;
  assign o_rx_data     = rx_head[7:0];
  assign o_rx_channel  = rx_head[8];

  fast_serial_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk      (i_clk),
    .reset    (i_reset),
    .wr_data  (i_tx_data),
    .wr_valid (i_tx_valid),
    .wr_ready (o_tx_ready),
    .rd_data  (tx_head),
    .rd_valid (tx_avail),
    .rd_ready (tx_pop),
    .level    (o_tx_level)
  );

  fast_serial_fifo #(
    .WIDTH (9),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk      (i_clk),
    .reset    (i_reset),
    .wr_data  (rx_sh),
    .wr_valid (rx_wr_pend),
    .wr_ready (rx_wr_ready),
    .rd_data  (rx_head),
    .rd_valid (o_rx_valid),
    .rd_ready (i_rx_ready),
    .level    (o_rx_level)
  );

endmodule

// File: tb/tb_fast_serial_link.sv
// tb/tb_fast_serial_link.sv - table-driven and sequence checks for fast_serial_link
`timescale 1ns/1ps
module tb_fast_serial_link;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_channel;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       rx_overflow;
  logic [4:0] tx_level;
  logic [4:0] rx_level;
  logic       fsclk;
  logic       fsdi;
  logic       fsdo = 1'b1;
  logic       fscts = 1'b0;
  logic       loopback = 1'b0;

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned edge_viol = 0;
  int unsigned low_samples = 0;
  int unsigned ovf_pulses = 0;
  logic prev_fsclk = 1'b0;
  logic prev_fsdi  = 1'b1;
  logic prev_rst   = 1'b1;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } tx_vec_t;

  tx_vec_t tx_vecs [5];
  tx_vec_t cts_vecs [3];

  always #5 clk = ~clk;

  fast_serial_link #(
    .CLK_DIV    (2),
    .TX_DEPTH   (16),
    .RX_DEPTH   (16),
    .TX_CHANNEL (1'b0)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
`ifdef FAST_SERIAL_LOOPBACK_EN
    .i_loopback    (loopback),
`endif
    .i_tx_data     (tx_data),
    .i_tx_valid    (tx_valid),
    .o_tx_ready    (tx_ready),
    .o_rx_data     (rx_data),
    .o_rx_channel  (rx_channel),
    .o_rx_valid    (rx_valid),
    .i_rx_ready    (rx_ready),
    .o_rx_overflow (rx_overflow),
    .o_tx_level    (tx_level),
    .o_rx_level    (rx_level),
    .o_fsclk       (fsclk),
    .o_fsdi        (fsdi),
    .i_fsdo        (fsdo),
    .i_fscts       (fscts)
  );

  always @(negedge clk) begin
    if ((fsdi !== prev_fsdi) && !(prev_fsclk && !fsclk) && !prev_rst) edge_viol <= edge_viol + 1;
    if (fsdi === 1'b0) low_samples <= low_samples + 1;
    if (rx_overflow === 1'b1) ovf_pulses <= ovf_pulses + 1;
    prev_fsclk <= fsclk;
    prev_fsdi  <= fsdi;
    prev_rst   <= reset;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_edge(input bit rising, output bit ok);
    logic p;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      p = fsclk;
      tick();
      if (rising && !p && fsclk) begin ok = 1'b1; break; end
      if (!rising && p && !fsclk) begin ok = 1'b1; break; end
    end
  endtask

  task automatic push(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic capture_frame(output logic [9:0] bits, output logic gap, output bit ok);
    bit r;
    ok = 1'b0;
    bits = '0;
    gap = 1'b0;
    for (int n = 0; n < 60; n++) begin
      wait_edge(1'b1, r);
      if (!r) break;
      if (fsdi === 1'b0) begin ok = 1'b1; break; end
    end
    if (ok) begin
      for (int b = 1; b < 10; b++) begin
        wait_edge(1'b1, r);
        if (!r) ok = 1'b0;
        bits[b] = fsdi;
      end
      wait_edge(1'b1, r);
      if (!r) ok = 1'b0;
      gap = fsdi;
    end
  endtask

  task automatic send_rx(input logic [7:0] d, input logic src);
    logic [9:0] f;
    bit r;
    f = {src, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      wait_edge(1'b0, r);
      fsdo = f[b];
    end
    wait_edge(1'b0, r);
    fsdo = 1'b1;
    wait_edge(1'b0, r);
    wait_edge(1'b0, r);
  endtask

  initial begin
    bit          ok;
    logic        gap;
    logic [9:0]  fr;
    logic        p;
    int          n;
    int          k;
    int unsigned base;
    logic [7:0]  ed;
    logic        ec;
    bit          r;

    tx_vecs[0] = '{8'hA5, 10'h14A};
    tx_vecs[1] = '{8'h00, 10'h000};
    tx_vecs[2] = '{8'hFF, 10'h1FE};
    tx_vecs[3] = '{8'h3C, 10'h078};
    tx_vecs[4] = '{8'h81, 10'h102};
    cts_vecs[0] = '{8'h11, 10'h022};
    cts_vecs[1] = '{8'h22, 10'h044};
    cts_vecs[2] = '{8'h33, 10'h066};

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    check("reset_tx_ready", 32'(tx_ready), 32'd0);
    check("reset_fsclk", 32'(fsclk), 32'd0);
    check("reset_fsdi", 32'(fsdi), 32'd1);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_rx_overflow", 32'(rx_overflow), 32'd0);
    check("reset_tx_level", 32'(tx_level), 32'd0);
    check("reset_rx_level", 32'(rx_level), 32'd0);

    reset = 1'b0;
    tick();
    n = 1;
    check("tx_ready_after_reset", 32'(tx_ready), 32'd1);
    while (fsclk !== 1'b1 && n < 20) begin tick(); n++; end
    check("first_fsclk_rise", 32'(n), 32'd2);
    n = 0;
    do begin
      p = fsclk;
      tick();
      n++;
    end while (!(!p && fsclk) && n < 20);
    check("fsclk_period", 32'(n), 32'd4);
    check("idle_fsdi_high", 32'(low_samples), 32'd0);

    // TX frames from a vector table
    fscts = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < 5; i++) begin
      push(tx_vecs[i].data);
      check("tx_level_after_push", 32'(tx_level), 32'd1);
      capture_frame(fr, gap, ok);
      check("tx_frame_found", 32'(ok), 32'd1);
      check("tx_frame_bits", 32'(fr), 32'(tx_vecs[i].frame));
      check("tx_gap_idle", 32'(gap), 32'd1);
    end

    // FSCTS low holds transmission
    fscts = 1'b0;
    repeat (8) tick();
    base = low_samples;
    for (int i = 0; i < 3; i++) push(cts_vecs[i].data);
    repeat (40) tick();
    check("cts_hold_fsdi_high", low_samples - base, 32'd0);
    check("cts_hold_level", 32'(tx_level), 32'd3);
    fscts = 1'b1;
    for (int i = 0; i < 3; i++) begin
      capture_frame(fr, gap, ok);
      check("cts_frame_found", 32'(ok), 32'd1);
      check("cts_frame_bits", 32'(fr), 32'(cts_vecs[i].frame));
      check("cts_gap_idle", 32'(gap), 32'd1);
    end
    check("cts_level_drained", 32'(tx_level), 32'd0);

    // RX: one frame, then fill to overflow
    rx_ready = 1'b0;
    send_rx(8'h3C, 1'b1);
    check("rx_valid", 32'(rx_valid), 32'd1);
    check("rx_data", 32'(rx_data), 32'h3C);
    check("rx_channel", 32'(rx_channel), 32'd1);
    check("rx_level_one", 32'(rx_level), 32'd1);
    base = ovf_pulses;
    for (int i = 0; i < 16; i++) send_rx(8'(8'h40 + i), i[0]);
    check("rx_level_full", 32'(rx_level), 32'd16);
    check("rx_overflow_pulses", ovf_pulses - base, 32'd1);
    for (int i = 0; i < 16; i++) begin
      if (i == 0) begin
        ed = 8'h3C;
        ec = 1'b1;
      end else begin
        k  = i - 1;
        ed = 8'(8'h40 + k);
        ec = k[0];
      end
      check("rx_drain_valid", 32'(rx_valid), 32'd1);
      check("rx_drain_data", 32'(rx_data), 32'(ed));
      check("rx_drain_channel", 32'(rx_channel), 32'(ec));
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
    end
    check("rx_empty_after_drain", 32'(rx_valid), 32'd0);
    check("rx_level_after_drain", 32'(rx_level), 32'd0);

    // Reset in the middle of a TX frame
    push(8'h5A);
    push(8'h77);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      wait_edge(1'b1, r);
      if (fsdi === 1'b0) begin ok = 1'b1; break; end
    end
    check("midreset_start_seen", 32'(ok), 32'd1);
    for (int i = 0; i < 4; i++) wait_edge(1'b1, r);
    reset = 1'b1;
    tick();
    check("midreset_fsdi", 32'(fsdi), 32'd1);
    check("midreset_fsclk", 32'(fsclk), 32'd0);
    check("midreset_tx_level", 32'(tx_level), 32'd0);
    check("midreset_rx_level", 32'(rx_level), 32'd0);
    reset = 1'b0;
    tick();
    push(8'hC3);
    capture_frame(fr, gap, ok);
    check("post_reset_frame_found", 32'(ok), 32'd1);
    check("post_reset_frame_bits", 32'(fr), 32'h186);
    check("post_reset_gap", 32'(gap), 32'd1);
    base = low_samples;
    repeat (80) tick();
    check("post_reset_no_stale_frame", low_samples - base, 32'd0);

`ifdef FAST_SERIAL_LOOPBACK_EN
    // Loopback: TX bytes return on RX, pin stays idle
    repeat (8) tick();
    loopback = 1'b1;
    fscts = 1'b0;
    base = low_samples;
    for (int i = 0; i < 16; i++) push(8'(i));
    n = 0;
    while (rx_level != 5'd16 && n < 3000) begin tick(); n++; end
    check("loop_rx_level", 32'(rx_level), 32'd16);
    check("loop_fsdi_high", low_samples - base, 32'd0);
    for (int i = 0; i < 16; i++) begin
      check("loop_data", 32'(rx_data), 32'(i));
      check("loop_channel", 32'(rx_channel), 32'd0);
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
    end
    loopback = 1'b0;
    fscts = 1'b1;
`endif

    check("fsdi_changes_on_fall_only", edge_viol, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
